mem_write_monitor: RTL and testbench
====================================

# mem_write_monitor

Synthesizable store-watch checker for the MIPS core's data-memory write port. Sits beside `top` on `memwrite`/`dataadr`/`writedata`. It compares every store against a runtime-programmable table of address/data signatures, counts cycles and stores, and ends the run as PASS, FAIL or TIMEOUT. A first-word-fall-through log FIFO records recent stores for debug readout.

## Interface
- `DW`, 64, store data width
- `AW`, 64, store address width
- `NSIG`, 4, number of signature entries (≥1)
- `TIMEOUT`, 1000, cycle count at which a run with no terminating hit is declared TIMEOUT (≥1)
- `CW`, 32, width of cycle/write/mark counters
- `LOGD`, 8, log FIFO depth (power of 2, ≥2)
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `memwrite` in 2: store strobe; any nonzero value is a store event
- `dataadr` in AW: store address
- `writedata` in DW: store data
- `cfg_we` in 1: signature table write
- `cfg_idx` in max(1,$clog2(NSIG)): entry index
- `cfg_adr` in AW: signature address
- `cfg_data` in DW: signature data
- `cfg_action` in 2: 00 disabled, 01 pass-stop, 10 mark (continue), 11 fail-stop
- `status` out 2: 00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT
- `done` out 1: `status != RUN`
- `hit_idx` out max(1,$clog2(NSIG)): entry that ended the run (0 on TIMEOUT)
- `cycle_cnt`, `write_cnt`, `mark_cnt` out CW each: counters
- `log_rd` in 1: pop log head
- `log_valid` out 1: log non-empty
- `log_adr` out AW, `log_data` out DW, `log_cycle` out CW: head entry
- `log_count` out $clog2(LOGD)+1: occupancy
- `log_overflow` out 1: sticky, an entry was dropped

## Operation
- Reset sets all outputs to 0, sets `status` to RUN, disables all table entries, and empties the log.
- Config: when `cfg_we` is set, entry `cfg_idx` is written on the clock edge. An out-of-range index is ignored. A store in the same cycle matches against the old table contents.
- Match: an enabled entry whose `cfg_adr == dataadr` and `cfg_data == writedata`, with a store event present. Exact full-width compare. If several entries match, the lowest index wins.
- RUN state, every cycle:
  - `cycle_cnt` increments.
  - On a store event, `write_cnt` increments and the store is pushed to the log with `log_cycle` = current `cycle_cnt` (pre-increment).
- Winning match in RUN:
  - pass-stop: go to PASS and latch `hit_idx`.
  - fail-stop: go to FAIL and latch `hit_idx`.
  - mark: `mark_cnt` increments and the state stays RUN.
- TIMEOUT: in RUN with `cycle_cnt == TIMEOUT-1` and no stop match that cycle, go to TIMEOUT. A stop match in that same cycle takes priority over the timeout.
- Terminal states (PASS/FAIL/TIMEOUT):
  - Held until reset.
  - All counters are frozen.
  - Stores are neither counted nor logged.
  - Config writes are still accepted.
  - Log pops still work.
- The store that terminates a run is counted and logged.
- Counters saturate at all-ones; they do not wrap.
- Log FIFO:
  - Push when full without a pop: the oldest entry is dropped and `log_overflow` is set.
  - Push and pop together when full: the head is consumed, the new entry is stored, and `log_overflow` is not set.
  - Pop when empty is ignored.
  - Pointers wrap modulo LOGD.

## Timing
- A store is sampled on the rising edge. `status`, `hit_idx`, counters and `log_count` reflect it in the following cycle, i.e. 1-cycle latency.
- Log is first-word-fall-through: the head fields are valid whenever `log_valid` is high.
- Push to an empty log: `log_valid` rises 1 cycle after the store.
- Pop: the next head entry is presented 1 cycle after the `log_rd` edge.
- First cycle after reset deasserts: `cycle_cnt` is 0 and `status` is RUN.
- Reset asserted mid-run: on the next edge everything returns to reset values, including the table and the log. A store in the reset cycle is ignored.

## Test plan
- Program entry 0 as (100, 7, pass-stop); store 7@100 at cycle 10. Required: `status` = 01 at the next cycle, `hit_idx` = 0, `write_cnt` = 1, and one log entry with `log_cycle` = 10.
- Program entries 1 (80, 1, fail-stop) and 2 (80, 1, pass-stop); store 1@80. Required: `status` = 10 and `hit_idx` = 1. Later stores leave `write_cnt` unchanged.
- Program entry 3 as (100, 6, mark); store 6@100 three times. Required: `mark_cnt` = 3 and `status` stays RUN.
- Set `TIMEOUT` = 20 and make no matching stores. Required: `status` = 11 in the cycle after `cycle_cnt` = 19, with `cycle_cnt` frozen at 20. A pass-stop store exactly at `cycle_cnt` = 19 must give PASS instead.
- Set `LOGD` = 4; make 6 stores with no pops. Required: `log_count` = 4, `log_overflow` = 1, and the head is the 3rd store. A push and pop together at full leaves `log_overflow` at 0 on a fresh run.
- Issue a `cfg_we` for (320, 4950, pass) in the same cycle as store 4950@320. Required: no hit. Repeating the store the next cycle gives PASS. Asserting reset mid-run clears the table, so the same store afterwards gives no hit.

Source files
------------

// File: rtl/mem_write_monitor.sv
// Store-watch checker for the data-memory write port. Stores are compared
// against a programmable table of address/data signatures. A hit can end the
// run as PASS or FAIL, or just bump a mark counter. The run ends as TIMEOUT
// if no stop hit arrives in time. Stores seen while running are kept in a
// small first-word-fall-through log for debug readout.
//
// Log handshake: log_valid high means the head fields are valid. log_rd pops
// the head on the rising edge. A pop while log_valid is low is ignored.
module mem_write_monitor #(
    parameter int  DW      = 64,
    parameter int  AW      = 64,
    parameter int  NSIG    = 4,
    parameter int  TIMEOUT = 1000,
    parameter int  CW      = 32,
    parameter int  LOGD    = 8,
    localparam int IW      = (NSIG > 1) ? $clog2(NSIG) : 1,
    localparam int PW      = $clog2(LOGD),
    localparam int LCW     = $clog2(LOGD) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     memwrite,
    input  logic [AW-1:0]  dataadr,
    input  logic [DW-1:0]  writedata,
    input  logic           cfg_we,
    input  logic [IW-1:0]  cfg_idx,
    input  logic [AW-1:0]  cfg_adr,
    input  logic [DW-1:0]  cfg_data,
    input  logic [1:0]     cfg_action,
    output logic [1:0]     status,
    output logic           done,
    output logic [IW-1:0]  hit_idx,
    output logic [CW-1:0]  cycle_cnt,
    output logic [CW-1:0]  write_cnt,
    output logic [CW-1:0]  mark_cnt,
    input  logic           log_rd,
    output logic           log_valid,
    output logic [AW-1:0]  log_adr,
    output logic [DW-1:0]  log_data,
    output logic [CW-1:0]  log_cycle,
    output logic [LCW-1:0] log_count,
    output logic           log_overflow
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    localparam logic [1:0]     ACT_OFF    = 2'b00;
    localparam logic [1:0]     ACT_PASS   = 2'b01;
    localparam logic [1:0]     ACT_MARK   = 2'b10;
    localparam logic [1:0]     ACT_FAIL   = 2'b11;
    localparam logic [CW-1:0]  CNT_MAX    = '1;
    localparam logic [CW-1:0]  LAST_CYCLE = CW'(TIMEOUT - 1);
    localparam logic [LCW-1:0] LOG_FULL   = LCW'(LOGD);

    state_t        state, state_next;
    logic [IW-1:0] hit_next;

    logic [AW-1:0] sig_adr  [NSIG];
    logic [DW-1:0] sig_data [NSIG];
    logic [1:0]    sig_act  [NSIG];

    logic          store, running;
    logic          match_any;
    logic [IW-1:0] match_idx;
    logic [1:0]    match_act;

    logic [AW-1:0] mem_adr   [LOGD];
    logic [DW-1:0] mem_data  [LOGD];
    logic [CW-1:0] mem_cycle [LOGD];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          push, pop, full;

    assign store   = |memwrite;
    assign running = (state == ST_RUN);
    assign status  = state;
    assign done    = (state != ST_RUN);

    // Signature table: written by the config port, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSIG; i++) begin
                sig_adr[i]  <= '0;
                sig_data[i] <= '0;
                sig_act[i]  <= ACT_OFF;
            end
        end else if (cfg_we && (int'(cfg_idx) < NSIG)) begin
            sig_adr[cfg_idx]  <= cfg_adr;
            sig_data[cfg_idx] <= cfg_data;
            sig_act[cfg_idx]  <= cfg_action;
        end
    end

    // Match search: scanning downwards leaves the lowest matching index.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        match_act = ACT_OFF;
        for (int i = NSIG - 1; i >= 0; i--) begin
            if (store && (sig_act[i] != ACT_OFF) &&
                (sig_adr[i] == dataadr) && (sig_data[i] == writedata)) begin
                match_any = 1'b1;
                match_idx = IW'(i);
                match_act = sig_act[i];
            end
        end
    end

    // Run state register together with the latched hit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            hit_idx <= '0;
        end else begin
            state   <= state_next;
            hit_idx <= hit_next;
        end
    end

    // Next state: a stop hit outranks the timeout in the same cycle.
    always_comb begin
        state_next = state;
        hit_next   = hit_idx;
        if (state == ST_RUN) begin
            if (match_any && (match_act == ACT_PASS)) begin
                state_next = ST_PASS;
                hit_next   = match_idx;
            end else if (match_any && (match_act == ACT_FAIL)) begin
                state_next = ST_FAIL;
                hit_next   = match_idx;
            end else if (cycle_cnt == LAST_CYCLE) begin
                state_next = ST_TIMEOUT;
                hit_next   = '0;
            end
        end
    end

    // Saturating counters; they advance only while the run is live.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            write_cnt <= '0;
            mark_cnt  <= '0;
        end else if (running) begin
            if (cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + CW'(1);
            if (store && (write_cnt != CNT_MAX)) write_cnt <= write_cnt + CW'(1);
            if (match_any && (match_act == ACT_MARK) && (mark_cnt != CNT_MAX))
                mark_cnt <= mark_cnt + CW'(1);
        end
    end

    assign push = running && store;
    assign pop  = log_rd && (log_count != '0);
    assign full = (log_count == LOG_FULL);

    // Log FIFO: a push into a full log without a pop drops the oldest entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            log_count    <= '0;
            log_overflow <= 1'b0;
            for (int i = 0; i < LOGD; i++) begin
                mem_adr[i]   <= '0;
                mem_data[i]  <= '0;
                mem_cycle[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_adr[wr_ptr]   <= dataadr;
                mem_data[wr_ptr]  <= writedata;
                mem_cycle[wr_ptr] <= cycle_cnt;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop || (push && full)) rd_ptr <= rd_ptr + PW'(1);
            if (push && full && !pop) log_overflow <= 1'b1;
            if (push && !pop && !full)
                log_count <= log_count + LCW'(1);
            else if (pop && !push)
                log_count <= log_count - LCW'(1);
        end
    end

    assign log_valid = (log_count != '0);
    assign log_adr   = mem_adr[rd_ptr];
    assign log_data  = mem_data[rd_ptr];
    assign log_cycle = mem_cycle[rd_ptr];

endmodule

// File: tb/tb_mem_write_monitor.sv
// Bench for mem_write_monitor: directed vectors for the documented scenarios
// plus randomized traffic checked against a queue-based reference model.
module tb_mem_write_monitor;
    localparam int DW = 64, AW = 64, NSIG = 5, TIMEOUT = 20, CW = 32, LOGD = 4;
    localparam int IW = 3, LCW = 3;
    localparam int W = AW + DW + CW;

    logic           clk = 1'b0, reset = 1'b0;
    logic [1:0]     memwrite;
    logic [AW-1:0]  dataadr, cfg_adr, log_adr;
    logic [DW-1:0]  writedata, cfg_data, log_data;
    logic           cfg_we, log_rd, done, log_valid, log_overflow;
    logic [IW-1:0]  cfg_idx, hit_idx;
    logic [1:0]     cfg_action, status;
    logic [CW-1:0]  cycle_cnt, write_cnt, mark_cnt, log_cycle;
    logic [LCW-1:0] log_count;

    mem_write_monitor #(.DW(DW), .AW(AW), .NSIG(NSIG), .TIMEOUT(TIMEOUT),
                        .CW(CW), .LOGD(LOGD)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_adr(cfg_adr), .cfg_data(cfg_data), .cfg_action(cfg_action),
        .status(status), .done(done), .hit_idx(hit_idx),
        .cycle_cnt(cycle_cnt), .write_cnt(write_cnt), .mark_cnt(mark_cnt),
        .log_rd(log_rd), .log_valid(log_valid), .log_adr(log_adr),
        .log_data(log_data), .log_cycle(log_cycle), .log_count(log_count),
        .log_overflow(log_overflow)
    );

    // Clock
    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // Reference model state; exp_q holds the expected log contents.
    logic [W-1:0]  exp_q[$];
    logic [1:0]    m_status;
    logic [IW-1:0] m_hit;
    logic [CW-1:0] m_cycle, m_wc, m_mc;
    logic          m_ovf;
    logic [AW-1:0] tbl_adr [NSIG];
    logic [DW-1:0] tbl_data[NSIG];
    logic [1:0]    tbl_act [NSIG];

    typedef struct {
        logic          cwe;
        logic [IW-1:0] idx;
        logic [63:0]   cadr, cdat;
        logic [1:0]    act, mw;
        logic [63:0]   adr, dat;
        logic [1:0]    e_status;
        logic [IW-1:0] e_hit;
        int            e_wc, e_mc, e_lc;
        logic          e_ovf;
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        memwrite = 2'b00; dataadr = '0; writedata = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_adr = '0; cfg_data = '0; cfg_action = 2'b00;
        log_rd = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_status = 2'b00; m_hit = '0; m_cycle = '0; m_wc = '0; m_mc = '0; m_ovf = 1'b0;
        for (int i = 0; i < NSIG; i++) begin
            tbl_adr[i] = '0; tbl_data[i] = '0; tbl_act[i] = 2'b00;
        end
    endtask

    // Applies one clock of the documented rules to the model using current inputs.
    task automatic model_step();
        int  win;
        logic st, popped;
        st = (memwrite != 2'b00);
        win = -1;
        for (int i = 0; i < NSIG; i++)
            if (st && win < 0 && tbl_act[i] != 2'b00 &&
                tbl_adr[i] == dataadr && tbl_data[i] == writedata) win = i;
        popped = 1'b0;
        if (log_rd && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            popped = 1'b1;
        end
        if (m_status == 2'b00) begin
            if (st) begin
                if (exp_q.size() == LOGD) begin
                    void'(exp_q.pop_front());
                    m_ovf = 1'b1;
                end
                exp_q.push_back({dataadr, writedata, m_cycle});
                if (m_wc != '1) m_wc = m_wc + 1;
            end
            if (win >= 0) begin
                case (tbl_act[win])
                    2'b01: begin m_status = 2'b01; m_hit = IW'(win); end
                    2'b11: begin m_status = 2'b10; m_hit = IW'(win); end
                    2'b10: if (m_mc != '1) m_mc = m_mc + 1;
                    default: ;
                endcase
            end
            if (m_status == 2'b00 && m_cycle == CW'(TIMEOUT - 1)) begin
                m_status = 2'b11;
                m_hit = '0;
            end
            if (m_cycle != '1) m_cycle = m_cycle + 1;
        end
        if (cfg_we && int'(cfg_idx) < NSIG) begin
            tbl_adr[cfg_idx] = cfg_adr; tbl_data[cfg_idx] = cfg_data; tbl_act[cfg_idx] = cfg_action;
        end
        if (popped) begin end
    endtask

    task automatic step();
        model_step();
        tick();
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        model_reset();
    endtask

    task automatic drive_cfg(input int idx, input logic [63:0] a, input logic [63:0] d, input logic [1:0] act);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_adr = a; cfg_data = d; cfg_action = act;
    endtask

    task automatic drive_store(input logic [1:0] mw, input logic [63:0] a, input logic [63:0] d);
        memwrite = mw; dataadr = a; writedata = d;
    endtask

    task automatic compare_model(input string tag);
        check({tag, " status"}, status, m_status);
        check({tag, " done"}, done, m_status != 2'b00);
        check({tag, " hit_idx"}, hit_idx, m_hit);
        check({tag, " cycle_cnt"}, cycle_cnt, m_cycle);
        check({tag, " write_cnt"}, write_cnt, m_wc);
        check({tag, " mark_cnt"}, mark_cnt, m_mc);
        check({tag, " log_count"}, log_count, exp_q.size());
        check({tag, " log_valid"}, log_valid, exp_q.size() > 0);
        check({tag, " log_overflow"}, log_overflow, m_ovf);
        if (exp_q.size() > 0) begin
            check({tag, " log_adr"}, log_adr, exp_q[0][W-1 -: AW]);
            check({tag, " log_data"}, log_data, exp_q[0][CW+DW-1 -: DW]);
            check({tag, " log_cycle"}, log_cycle, exp_q[0][CW-1:0]);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        do_reset();

        // Reset state
        check("rst status", status, 0);
        check("rst done", done, 0);
        check("rst hit_idx", hit_idx, 0);
        check("rst cycle_cnt", cycle_cnt, 0);
        check("rst write_cnt", write_cnt, 0);
        check("rst mark_cnt", mark_cnt, 0);
        check("rst log_valid", log_valid, 0);
        check("rst log_count", log_count, 0);
        check("rst log_overflow", log_overflow, 0);
        check("rst log_adr", log_adr, 0);

        // Pass-stop hit at cycle 10
        drive_cfg(0, 100, 7, 2'b01);
        step();
        for (int k = 1; k < 10; k++) step();
        check("t1 cycle before store", cycle_cnt, 10);
        drive_store(2'b01, 100, 7);
        step();
        check("t1 status", status, 1);
        check("t1 done", done, 1);
        check("t1 hit_idx", hit_idx, 0);
        check("t1 write_cnt", write_cnt, 1);
        check("t1 log_count", log_count, 1);
        check("t1 log_cycle", log_cycle, 10);
        check("t1 log_adr", log_adr, 100);
        check("t1 log_data", log_data, 7);
        drive_store(2'b01, 100, 7);
        step();
        check("t1 frozen cycle", cycle_cnt, 11);
        check("t1 frozen write_cnt", write_cnt, 1);

        // Table-driven sequence: marks, same-cycle config, out-of-range index, priority
        vecs[0]  = '{1'b1, 3'd3, 64'd100, 64'd6,    2'b10, 2'b00, 64'd0,   64'd0,    2'b00, 3'd0, 0, 0, 0, 1'b0};
        vecs[1]  = '{1'b1, 3'd1, 64'd80,  64'd1,    2'b11, 2'b00, 64'd0,   64'd0,    2'b00, 3'd0, 0, 0, 0, 1'b0};
        vecs[2]  = '{1'b1, 3'd2, 64'd80,  64'd1,    2'b01, 2'b00, 64'd0,   64'd0,    2'b00, 3'd0, 0, 0, 0, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 64'd0,   64'd0,    2'b00, 2'b01, 64'd100, 64'd6,    2'b00, 3'd0, 1, 1, 1, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 64'd0,   64'd0,    2'b00, 2'b10, 64'd100, 64'd6,    2'b00, 3'd0, 2, 2, 2, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 64'd0,   64'd0,    2'b00, 2'b11, 64'd100, 64'd6,    2'b00, 3'd0, 3, 3, 3, 1'b0};
        vecs[6]  = '{1'b1, 3'd0, 64'd320, 64'd4950, 2'b01, 2'b01, 64'd320, 64'd4950, 2'b00, 3'd0, 4, 3, 4, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 64'd0,   64'd0,    2'b00, 2'b01, 64'd100, 64'd7,    2'b00, 3'd0, 5, 3, 4, 1'b1};
        vecs[8]  = '{1'b1, 3'd5, 64'd55,  64'd5,    2'b01, 2'b00, 64'd0,   64'd0,    2'b00, 3'd0, 5, 3, 4, 1'b1};
        vecs[9]  = '{1'b0, 3'd0, 64'd0,   64'd0,    2'b00, 2'b01, 64'd55,  64'd5,    2'b00, 3'd0, 6, 3, 4, 1'b1};
        vecs[10] = '{1'b0, 3'd0, 64'd0,   64'd0,    2'b00, 2'b01, 64'd80,  64'd1,    2'b10, 3'd1, 7, 3, 4, 1'b1};
        vecs[11] = '{1'b0, 3'd0, 64'd0,   64'd0,    2'b00, 2'b01, 64'd80,  64'd1,    2'b10, 3'd1, 7, 3, 4, 1'b1};
        vecs[12] = '{1'b0, 3'd0, 64'd0,   64'd0,    2'b00, 2'b01, 64'd320, 64'd4950, 2'b10, 3'd1, 7, 3, 4, 1'b1};
        do_reset();
        for (int v = 0; v < 13; v++) begin
            if (vecs[v].cwe) drive_cfg(int'(vecs[v].idx), vecs[v].cadr, vecs[v].cdat, vecs[v].act);
            drive_store(vecs[v].mw, vecs[v].adr, vecs[v].dat);
            step();
            check($sformatf("vec%0d status", v), status, vecs[v].e_status);
            check($sformatf("vec%0d hit_idx", v), hit_idx, vecs[v].e_hit);
            check($sformatf("vec%0d write_cnt", v), write_cnt, vecs[v].e_wc);
            check($sformatf("vec%0d mark_cnt", v), mark_cnt, vecs[v].e_mc);
            check($sformatf("vec%0d log_count", v), log_count, vecs[v].e_lc);
            check($sformatf("vec%0d log_overflow", v), log_overflow, vecs[v].e_ovf);
        end

        // Config and store in one cycle; then repeat; then reset mid-run clears table
        do_reset();
        drive_cfg(0, 320, 4950, 2'b01);
        drive_store(2'b01, 320, 4950);
        step();
        check("same-cycle cfg status", status, 0);
        drive_store(2'b01, 320, 4950);
        step();
        check("repeat store status", status, 1);
        check("repeat store hit_idx", hit_idx, 0);
        check("repeat store write_cnt", write_cnt, 2);
        do_reset();
        drive_cfg(0, 320, 4950, 2'b01);
        step();
        step();
        drive_store(2'b01, 320, 4950);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        model_reset();
        check("mid reset cycle_cnt", cycle_cnt, 0);
        check("mid reset write_cnt", write_cnt, 0);
        check("mid reset log_count", log_count, 0);
        drive_store(2'b01, 320, 4950);
        step();
        check("after reset no hit", status, 0);
        check("after reset write_cnt", write_cnt, 1);

        // Timeout
        do_reset();
        for (int k = 0; k < 19; k++) step();
        check("to cycle 19", cycle_cnt, 19);
        check("to still run", status, 0);
        step();
        check("to status", status, 3);
        check("to cycle frozen", cycle_cnt, 20);
        check("to hit_idx", hit_idx, 0);
        drive_store(2'b01, 1, 1);
        step();
        check("to cycle hold", cycle_cnt, 20);
        check("to store ignored", write_cnt, 0);
        check("to not logged", log_count, 0);

        // Pass-stop on the timeout cycle
        do_reset();
        drive_cfg(0, 100, 7, 2'b01);
        step();
        for (int k = 1; k < 19; k++) step();
        drive_store(2'b01, 100, 7);
        step();
        check("pass@19 status", status, 1);
        check("pass@19 cycle", cycle_cnt, 20);

        // Log overflow, drain, pop on empty
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive_store(2'b01, 64'(1000 + k), 64'(50 + k));
            step();
        end
        check("ovf log_count", log_count, 4);
        check("ovf flag", log_overflow, 1);
        check("ovf head adr", log_adr, 1002);
        check("ovf head cycle", log_cycle, 2);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d adr", k), log_adr, 64'(1002 + k));
            check($sformatf("drain%0d data", k), log_data, 64'(52 + k));
            log_rd = 1'b1;
            step();
        end
        check("drained valid", log_valid, 0);
        log_rd = 1'b1;
        step();
        check("pop empty count", log_count, 0);
        check("pop empty ovf sticky", log_overflow, 1);

        // Push and pop together at full
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_store(2'b01, 64'(2000 + k), 64'(k));
            step();
        end
        drive_store(2'b01, 2004, 4);
        log_rd = 1'b1;
        step();
        check("pushpop count", log_count, 4);
        check("pushpop ovf", log_overflow, 0);
        check("pushpop head", log_adr, 2001);
        drive_store(2'b01, 2005, 5);
        step();
        check("full push ovf", log_overflow, 1);
        check("full push head", log_adr, 2002);

        // Randomized traffic against the reference model
        for (int run = 0; run < 10; run++) begin
            do_reset();
            compare_model($sformatf("r%0d init", run));
            for (int c = 0; c < 26; c++) begin
                if ($urandom_range(0, 2) == 0)
                    drive_cfg($urandom_range(0, 7), 64'(100 * $urandom_range(1, 3)),
                              64'($urandom_range(1, 2)), 2'($urandom_range(0, 3)));
                drive_store(2'($urandom_range(0, 3)), 64'(100 * $urandom_range(1, 3)),
                            64'($urandom_range(1, 2)));
                log_rd = ($urandom_range(0, 3) == 0);
                step();
                compare_model($sformatf("r%0d c%0d", run, c));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
